pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the program-counter register's next value and runs
// the instruction-fetch handshake (request -> ack -> hold -> issue).
// Optional fetch watchdog: define PC_SEQ_FETCH_TIMEOUT_EN to enable the
// imem_ack timeout, the FAULT state and the fault pulse. Without the macro
// REQ/DRAIN wait indefinitely and fault is tied low.
module pc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        fault
);

    // Reject configurations the watchdog and trap fetch cannot honour.
    if (TIMEOUT_CYCLES == 0 || TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_params
        $error("pc_sequencer: TIMEOUT_CYCLES must be >= 1 and TRAP_VECTOR word aligned");
    end

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_e;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_pc_q;
    logic        fetch_done;
    logic        wdog_expired;

    // A fetch completes when the memory answers in REQ and nobody redirected.
    assign fetch_done = (state_q == REQ) && imem_ack && !redirect;

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             in_fetch;

    assign in_fetch     = (state_q == REQ) || (state_q == DRAIN);
    // wdog_q counts the cycles already spent waiting, so this is the last allowed one.
    assign wdog_expired = in_fetch && !imem_ack && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fault        = (state_q == FAULT);

    // Watchdog: count while waiting in REQ/DRAIN, clear on ack or any state change.
    always_comb begin
        wdog_d = '0;
        if (in_fetch && !imem_ack && (state_d == state_q)) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expired = 1'b0;
    assign fault        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect outranks stall and ready; the watchdog outranks all.
    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!redirect && !stall) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_d = redirect ? IDLE : HOLD;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = IDLE;
                end else if (instr_ready) begin
                    state_d = stall ? IDLE : REQ;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
            FAULT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        if (wdog_expired) begin
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
            state_d = FAULT;
`else
            state_d = IDLE;
`endif
        end
    end

    // Outputs: request/valid decoded from state; next_pc holds unless advanced or redirected.
    always_comb begin
        next_pc     = pc;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_pc = pc + 32'd4;
                end
            end
            HOLD:  instr_valid = 1'b1;
            DRAIN: imem_req    = 1'b1;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
            FAULT: next_pc     = TRAP_VECTOR;
`endif
            default: ;
        endcase
        if (redirect) begin
            next_pc = {redirect_pc[31:2], 2'b00};
        end
        if (reset) begin
            next_pc = '0;
        end
    end

    // Captured instruction and its fetch address, held stable through HOLD.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: these data registers are reset on purpose so instr/instr_pc read 0 after reset.
        if (reset) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (fetch_done) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc;
        end
    end

    assign imem_addr = pc;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios push expected fetch
// acks and expected issued instructions; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] TRAP    = 32'h0000_0100;

    typedef struct packed { logic [31:0] addr; logic [31:0] nxt; } fetch_t;
    typedef struct packed { logic [31:0] word; logic [31:0] addr; } issue_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b1;
    logic        fault;

    logic        mem_on = 1'b0;
    logic        late_ack = 1'b0;
    int unsigned ack_delay = 0;
    int unsigned req_cycles;

    int n_compared = 0;
    int n_mismatched = 0;
    fetch_t fetch_q[$];
    issue_t issue_q[$];

    pc_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .TRAP_VECTOR(TRAP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // Program-counter register that the sequencer steers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= next_pc;
    end

    // Memory model: acks after ack_delay waiting cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      req_cycles <= 0;
        else if (imem_req && !imem_ack) req_cycles <= req_cycles + 1;
        else                            req_cycles <= 0;
    end

    always_comb begin
        imem_ack   = late_ack || (mem_on && imem_req && (req_cycles >= ack_delay));
        imem_rdata = data_of(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] nxt, input bit issued);
        fetch_q.push_back('{addr: a, nxt: nxt});
        if (issued) issue_q.push_back('{word: data_of(a), addr: a});
    endtask

    task automatic fetch_run(input int n);
        int seen = 0;
        int cyc = 0;
        stall = 1'b0;
        while (seen < n && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
            if (instr_valid && instr_ready && !redirect) begin
                seen++;
                if (seen == n) stall = 1'b1;
            end
        end
        check("fetch_run_done", 32'(seen), 32'(n));
    endtask

    // Monitor: compares fetch acks and accepted instructions against the queues.
    initial begin
        logic   prev_req;
        logic   prev_ack;
        fetch_t f;
        issue_t s;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!reset) begin
                if (prev_req && !prev_ack) check("req_held", 32'(imem_req | fault), 32'd1);
                if (imem_req && imem_ack) begin
                    if (fetch_q.size() == 0) begin
                        n_compared++; n_mismatched++;
                        $display("FAIL fetch_extra: ack at addr %h, none expected", imem_addr);
                    end else begin
                        f = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, f.addr);
                        check("fetch_next_pc", next_pc, f.nxt);
                    end
                end
                if (instr_valid && instr_ready && !redirect) begin
                    if (issue_q.size() == 0) begin
                        n_compared++; n_mismatched++;
                        $display("FAIL issue_extra: instr %h pc %h, none expected", instr, instr_pc);
                    end else begin
                        s = issue_q.pop_front();
                        check("issue_instr", instr, s.word);
                        check("issue_pc", instr_pc, s.addr);
                    end
                end
            end
            prev_req = imem_req;
            prev_ack = imem_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int reqs;
        int faults;

        // Reset state.
        @(negedge clk); #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_next_pc", next_pc, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Sequential fetch, zero-wait memory, always ready.
        for (int k = 0; k < 6; k++) expect_fetch(32'(4 * k), 32'(4 * k + 4), 1'b1);
        @(negedge clk);
        reset = 1'b0; instr_ready = 1'b1; mem_on = 1'b1; ack_delay = 0;
        fetch_run(6);

        // Redirect from IDLE to an unaligned target, then the wrap-around fetch.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1;
        check("idle_redirect_next_pc", next_pc, 32'hFFFF_FFFC);
        check("idle_redirect_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        expect_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        fetch_run(1);

        // Redirect during a slow REQ: drain the stale word, refetch at the target.
        @(negedge clk);
        ack_delay = 3; stall = 1'b0;
        expect_fetch(32'h0000_2000, 32'h0000_2000, 1'b0);
        expect_fetch(32'h0000_2000, 32'h0000_2004, 1'b1);
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (!imem_req && cyc < 20);
        check("req_entered", 32'(imem_req), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        #1;
        check("req_redirect_next_pc", next_pc, 32'h0000_2000);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("drain_req_held", 32'(imem_req), 32'd1);
        check("drain_addr", imem_addr, 32'h0000_2000);
        fetch_run(1);

        // HOLD with instr_ready low, then redirect on the third valid cycle.
        @(negedge clk);
        ack_delay = 0; instr_ready = 1'b0; stall = 1'b0;
        expect_fetch(32'h0000_2004, 32'h0000_2008, 1'b0);
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (!instr_valid && cyc < 20);
        stall = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, data_of(32'h0000_2004));
            check("hold_instr_pc", instr_pc, 32'h0000_2004);
            if (c < 3) begin @(negedge clk); #1; end
        end
        redirect = 1'b1; redirect_pc = 32'h0000_3000; instr_ready = 1'b1;
        #1;
        check("hold_redirect_next_pc", next_pc, 32'h0000_3000);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("hold_redirect_drop", 32'(instr_valid), 32'd0);

        // Reset mid-fetch, followed by a late ack.
        @(negedge clk);
        mem_on = 1'b0; stall = 1'b0;
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (!imem_req && cyc < 20);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_instr_pc", instr_pc, 32'd0);
        check("midrst_next_pc", next_pc, 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b1; late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("late_ack_no_valid", 32'(instr_valid), 32'd0);
        end

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
        // Watchdog: no ack for TIMEOUT cycles, trap, then resume at the vector.
        @(negedge clk);
        stall = 1'b0;
        reqs = 0; faults = 0; cyc = 0;
        while (faults == 0 && cyc < 60) begin
            @(negedge clk); #1; cyc++;
            if (imem_req) reqs++;
            if (fault) faults++;
        end
        check("wdog_fault_seen", 32'(fault), 32'd1);
        check("wdog_req_cycles", 32'(reqs), 32'(TIMEOUT));
        check("wdog_next_pc", next_pc, TRAP);
        check("wdog_req_dropped", 32'(imem_req), 32'd0);
        mem_on = 1'b1;
        expect_fetch(TRAP, TRAP + 32'd4, 1'b1);
        @(negedge clk); #1;
        check("wdog_fault_one_cycle", 32'(fault), 32'd0);
        fetch_run(1);
`else
        // Without the watchdog a missing ack just keeps the request up.
        @(negedge clk);
        stall = 1'b0;
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (!imem_req && cyc < 20);
        reqs = 0; faults = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (imem_req) reqs++;
            if (fault) faults++;
        end
        check("nowdog_req_cycles", 32'(reqs), 32'd20);
        check("nowdog_no_fault", 32'(faults), 32'd0);
        mem_on = 1'b1;
        expect_fetch(32'h0000_0000, 32'h0000_0004, 1'b1);
        fetch_run(1);
`endif

        @(negedge clk); #3;
        check("fetch_queue_empty", 32'(fetch_q.size()), 32'd0);
        check("issue_queue_empty", 32'(issue_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
